// File: rtl/shift_reg_n.sv
// shift_reg_n: WIDTH-bit loadable shift register that tracks a loaded word through busy/done.
// Optional running parity output is built when SHIFT_REG_PARITY_EN is defined.
module shift_reg_n #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned LSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enp,
   input  logic             load,
   input  logic             shift,
   input  logic             sdin,
   input  logic [WIDTH-1:0] pdin,
   output logic             sdout,
   output logic [WIDTH-1:0] pdout,
   output logic             busy,
   output logic             done
`ifdef SHIFT_REG_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SHIFTING = 2'd1,
      S_DONE     = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_reg;
   logic [CNT_W-1:0] r_count;
   logic             r_busy;
   logic             r_done;

   logic             w_load;
   logic             w_shift;
   logic             w_sout;
   logic [WIDTH-1:0] w_shifted;

   // Load beats shift on the same qualified edge.
   assign w_load  = enp & load;
   assign w_shift = enp & shift & ~load;

   if (LSB_FIRST != 0) begin : g_lsb
      assign w_sout    = r_reg[0];
      assign w_shifted = {sdin, r_reg[WIDTH-1:1]};
   end else begin : g_msb
      assign w_sout    = r_reg[WIDTH-1];
      assign w_shifted = {r_reg[WIDTH-2:0], sdin};
   end

   assign sdout = w_sout;
   assign pdout = r_reg;
   assign busy  = r_busy;
   assign done  = r_done;

   // Data register, word counter and word-tracking state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_reg   <= '0;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (w_load) begin
            r_reg <= pdin;
         end else if (w_shift) begin
            r_reg <= w_shifted;
         end

         case (r_state)
            S_SHIFTING: begin
               if (w_load) begin
                  r_count <= CNT_W'(WIDTH);
               end else if (w_shift) begin
                  r_count <= r_count - CNT_W'(1);
                  if (r_count == CNT_W'(1)) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_IDLE, S_DONE: begin
               // done lasts one cycle whatever enp does; free-running shifts leave count at 0.
               if (w_load) begin
                  r_state <= S_SHIFTING;
                  r_count <= CNT_W'(WIDTH);
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_count <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SHIFT_REG_PARITY_EN
   logic r_parity;

   // Parity of the bits of the current word shifted out so far.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity <= 1'b0;
      end else if (w_load) begin
         r_parity <= 1'b0;
      end else if (w_shift && r_busy) begin
         r_parity <= r_parity ^ w_sout;
      end
   end

   assign parity = r_parity;
`endif

endmodule

// File: tb/tb_shift_reg_n.sv
// tb_shift_reg_n: scoreboard bench for shift_reg_n, one LSB-first and one MSB-first instance.
// Parity checks are included when SHIFT_REG_PARITY_EN is defined.
module tb_shift_reg_n;

   logic       clk;
   logic       rst_n;
   logic       enp;
   logic       load;
   logic       shift;
   logic       sdin;
   logic [7:0] pdin;

   logic       sdout_l, sdout_m;
   logic [7:0] pdout_l, pdout_m;
   logic       busy_l, busy_m;
   logic       done_l, done_m;
`ifdef SHIFT_REG_PARITY_EN
   logic       parity_l, parity_m;
`endif

   shift_reg_n #(.WIDTH(8), .LSB_FIRST(1)) u_dut_lsb (
      .clk(clk), .rst_n(rst_n), .enp(enp), .load(load), .shift(shift),
      .sdin(sdin), .pdin(pdin), .sdout(sdout_l), .pdout(pdout_l),
      .busy(busy_l), .done(done_l)
`ifdef SHIFT_REG_PARITY_EN
      , .parity(parity_l)
`endif
   );

   shift_reg_n #(.WIDTH(8), .LSB_FIRST(0)) u_dut_msb (
      .clk(clk), .rst_n(rst_n), .enp(enp), .load(load), .shift(shift),
      .sdin(sdin), .pdin(pdin), .sdout(sdout_m), .pdout(pdout_m),
      .busy(busy_m), .done(done_m)
`ifdef SHIFT_REG_PARITY_EN
      , .parity(parity_m)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          dut;
      int          kind;
      logic [31:0] val;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_err = 0;

   // Reference model state, index 0 = LSB-first, 1 = MSB-first.
   logic [7:0] m_reg  [2];
   int         m_cnt  [2];
   logic       m_busy [2];
   logic       m_done [2];
   logic       m_par  [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] obs(input int d, input int k);
      logic [31:0] v;
      v = '0;
      case (k)
         0: v = (d == 0) ? 32'(pdout_l) : 32'(pdout_m);
         1: v = (d == 0) ? 32'(busy_l)  : 32'(busy_m);
         2: v = (d == 0) ? 32'(done_l)  : 32'(done_m);
         3: v = (d == 0) ? 32'(sdout_l) : 32'(sdout_m);
`ifdef SHIFT_REG_PARITY_EN
         4: v = (d == 0) ? 32'(parity_l) : 32'(parity_m);
`endif
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_reg[d] = '0; m_cnt[d] = 0; m_busy[d] = 1'b0; m_done[d] = 1'b0; m_par[d] = 1'b0;
      end
   endtask

   task automatic model_step(input logic en, input logic ld, input logic sh, input logic sd,
                             input logic [7:0] pd);
      logic nd;
      logic out;
      for (int d = 0; d < 2; d++) begin
         nd = 1'b0;
         if (en && ld) begin
            m_reg[d] = pd; m_cnt[d] = 8; m_busy[d] = 1'b1; m_par[d] = 1'b0;
         end else if (en && sh) begin
            out = (d == 0) ? m_reg[d][0] : m_reg[d][7];
            m_reg[d] = (d == 0) ? {sd, m_reg[d][7:1]} : {m_reg[d][6:0], sd};
            if (m_busy[d]) begin
               m_par[d] = m_par[d] ^ out;
               m_cnt[d] = m_cnt[d] - 1;
               if (m_cnt[d] == 0) begin
                  m_busy[d] = 1'b0;
                  nd = 1'b1;
               end
            end
         end
         m_done[d] = nd;
      end
   endtask

   task automatic push_expect(input string tag);
      for (int d = 0; d < 2; d++) begin
         sb.push_back('{tag: {tag, "_pdout"}, dut: d, kind: 0, val: 32'(m_reg[d])});
         sb.push_back('{tag: {tag, "_busy"},  dut: d, kind: 1, val: 32'(m_busy[d])});
         sb.push_back('{tag: {tag, "_done"},  dut: d, kind: 2, val: 32'(m_done[d])});
         sb.push_back('{tag: {tag, "_sdout"}, dut: d, kind: 3,
                        val: 32'((d == 0) ? m_reg[d][0] : m_reg[d][7])});
`ifdef SHIFT_REG_PARITY_EN
         sb.push_back('{tag: {tag, "_parity"}, dut: d, kind: 4, val: 32'(m_par[d])});
`endif
      end
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("%s[%0d]", e.tag, e.dut), obs(e.dut, e.kind), e.val);
      end
   endtask

   // One clock of stimulus: drive at negedge, compare 1ns after the rising edge.
   task automatic step(input logic en, input logic ld, input logic sh, input logic sd,
                       input logic [7:0] pd, input string tag);
      @(negedge clk);
      enp = en; load = ld; shift = sh; sdin = sd; pdin = pd;
      model_step(en, ld, sh, sd, pd);
      push_expect(tag);
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      logic [7:0] w;
      rst_n = 1'b0; enp = 1'b0; load = 1'b0; shift = 1'b0; sdin = 1'b0; pdin = '0;
      model_reset();
      #12;
      check("rst_pdout_l", 32'(pdout_l), 32'h0);
      check("rst_pdout_m", 32'(pdout_m), 32'h0);
      check("rst_busy",    32'(busy_l),  32'h0);
      check("rst_done",    32'(done_l),  32'h0);
      check("rst_sdout",   32'(sdout_l), 32'h0);
      rst_n = 1'b1;

      // Load 0xA5 and shift out with sdin=0.
      w = 8'hA5;
      step(1, 1, 0, 0, w, "ld_a5");
      for (int i = 0; i < 8; i++) begin
         check($sformatf("seq_lsb_%0d", i), 32'(sdout_l), 32'(w[i]));
         check($sformatf("seq_msb_%0d", i), 32'(sdout_m), 32'(w[7-i]));
         step(1, 0, 1, 0, 8'h00, "sh_a5");
      end
      check("a5_done_l",  32'(done_l),  32'h1);
      check("a5_done_m",  32'(done_m),  32'h1);
      check("a5_pdout_l", 32'(pdout_l), 32'h0);
      check("a5_busy_l",  32'(busy_l),  32'h0);
      step(0, 0, 0, 0, 8'h00, "done_clr");
      check("done_pulse", 32'(done_l), 32'h0);

      // Free-running shift while idle: register moves, no done.
      for (int i = 0; i < 9; i++) step(1, 0, 1, 1'(i & 1), 8'h00, "free");

      // enp gaps between shifts of 0xFF.
      step(1, 1, 0, 0, 8'hFF, "ld_ff");
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 1, 0, 8'h00, "sh_ff");
         for (int j = 0; j < 5; j++) step(0, 1'(j & 1), 1, 1, 8'h5A, "hold");
         if (i < 7) check("ff_no_early_done", 32'(done_l), 32'h0);
      end
      step(1, 0, 0, 0, 8'h00, "ff_after");

      // Load on the final shift edge.
      step(1, 1, 0, 0, 8'hA5, "ld_a5b");
      for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 8'h00, "sh_a5b");
      step(1, 1, 1, 0, 8'h3C, "ld_on_last");
      check("collide_done",  32'(done_l),  32'h0);
      check("collide_busy",  32'(busy_l),  32'h1);
      check("collide_pdout", 32'(pdout_l), 32'h3C);
      w = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("seq3c_lsb_%0d", i), 32'(sdout_l), 32'(w[i]));
         check($sformatf("seq3c_msb_%0d", i), 32'(sdout_m), 32'(w[7-i]));
         step(1, 0, 1, 0, 8'h00, "sh_3c");
      end
      check("3c_done", 32'(done_m), 32'h1);

      // Mid-word reload aborts without done.
      step(1, 1, 0, 0, 8'h81, "ld_81");
      for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 8'h00, "sh_81");
      step(1, 1, 0, 0, 8'h66, "reld_66");
      for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 8'h00, "sh_66");

`ifdef SHIFT_REG_PARITY_EN
      step(1, 1, 0, 0, 8'h07, "ld_07");
      for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 8'h00, "sh_07");
      check("par_07_l", 32'(parity_l), 32'h1);
      check("par_07_m", 32'(parity_m), 32'h1);
      step(1, 1, 0, 0, 8'h03, "ld_03");
      for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 8'h00, "sh_03");
      check("par_03_l", 32'(parity_l), 32'h0);
      check("par_03_m", 32'(parity_m), 32'h0);
`endif

      // Asynchronous reset after 3 shifts, away from any clock edge.
      step(1, 1, 0, 0, 8'hA5, "ld_rst");
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'h00, "sh_rst");
      #2;
      enp = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_pdout_l", 32'(pdout_l), 32'h0);
      check("arst_pdout_m", 32'(pdout_m), 32'h0);
      check("arst_busy_l",  32'(busy_l),  32'h0);
      check("arst_busy_m",  32'(busy_m),  32'h0);
      check("arst_sdout_m", 32'(sdout_m), 32'h0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 8'h00, "post_rst");

      // Randomised traffic against the model.
      for (int i = 0; i < 150; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_reg_n.md
SHIFT_REG_N -- requirements
Module: shift_reg_n

Interface
REQ-001 Parameter WIDTH, default 8, register length in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1; 1 = shift toward bit 0, 0 = shift toward bit WIDTH-1.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enp  input  1  enable pulse; load and shift act only on edges where enp=1.
REQ-006 load  input  1  parallel load request.
REQ-007 shift  input  1  shift request.
REQ-008 sdin  input  1  serial data in.
REQ-009 pdin  input  WIDTH  parallel data in.
REQ-010 sdout  output  1  serial data out.
REQ-011 pdout  output  WIDTH  register contents.
REQ-012 busy  output  1  a loaded word is still being shifted out.
REQ-013 done  output  1  one-clk pulse after the last bit of a loaded word is shifted.
REQ-014 parity  output  1  running parity; present only with SHIFT_REG_PARITY_EN.

Function
REQ-015 pdout SHALL equal the internal register at all times.
REQ-016 sdout SHALL be combinational: reg[0] when LSB_FIRST=1, reg[WIDTH-1] when LSB_FIRST=0.
REQ-017 Bit counter width SHALL be clog2(WIDTH+1); it holds the number of bits still to shift.
REQ-018 On clk edge with enp=1 and load=1: reg<=pdin, count<=WIDTH, busy<=1; shift ignored (load has priority).
REQ-019 On clk edge with enp=1, load=0, shift=1: LSB_FIRST=1 gives reg<={sdin, reg[WIDTH-1:1]}; LSB_FIRST=0 gives reg<={reg[WIDTH-2:0], sdin}.
REQ-020 During REQ-019 with busy=1, count SHALL decrement by 1; when count goes 1->0, busy<=0 and done<=1 on the same edge.
REQ-021 Shift with busy=0 SHALL still shift the register (free-running mode); count stays 0, done not asserted.
REQ-022 enp=0 SHALL hold reg, count and busy regardless of load/shift.
REQ-023 done SHALL be high for exactly one clk cycle and clear on the next edge independent of enp.
REQ-024 Load on the same edge as the final shift of the previous word: load wins, done stays 0, busy stays 1, count=WIDTH.
REQ-025 Load while busy (mid-word) SHALL abort the current word without done and restart with count=WIDTH.
REQ-026 States: IDLE (busy=0), SHIFTING (busy=1), DONE (done=1, busy=0, one cycle, then IDLE); DONE->SHIFTING directly on load.

Reset
REQ-027 rst_n=0 SHALL immediately force reg=0, count=0, busy=0, done=0 and parity=0, hence sdout=0 and pdout=0.
REQ-028 Reset asserted mid-word SHALL abort without a done pulse; operation resumes on the first enp-qualified edge after rst_n=1.

Configuration
REQ-029 Macro SHIFT_REG_PARITY_EN defined: port parity exists; it is cleared on load and XORed with the outgoing sdout bit on each enp-qualified shift edge while busy=1.
REQ-030 Macro undefined: no parity port and no parity register; all other behaviour identical.

Verification
REQ-031 WIDTH=8, LSB_FIRST=1: load 0xA5, 8 shifts with sdin=0 -> sdout sequence 1,0,1,0,0,1,0,1; done one cycle after the 8th shift; pdout=0x00; busy=0.
REQ-032 LSB_FIRST=0, WIDTH=8: load 0xA5 -> sdout sequence 1,0,1,0,0,1,0,1 (MSB first); done after 8 shifts.
REQ-033 Load 0xFF, then toggle enp low for 5 cycles between shifts -> state unchanged while enp=0; done only after the 8th enp-qualified shift.
REQ-034 Load on the edge of the 8th shift -> no done; busy stays 1; count=8; new word shifts out cleanly.
REQ-035 Assert rst_n=0 after 3 shifts -> pdout=0, busy=0 immediately without waiting for clk; no done pulse after release.
REQ-036 SHIFT_REG_PARITY_EN defined: load 0x07, 8 shifts -> parity=1; load 0x03, 8 shifts -> parity=0.
